// File: rtl/serial_add_sub_unit.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, through a
// single full-adder cell with a registered carry. Start/busy/done handshake.
module serial_add_sub_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             busy_q, done_q, cout_q, v_q;
  logic [WIDTH-1:0] s_q;

  logic             sum_bit;
  logic             carry_d;
  logic [WIDTH-1:0] res_d;

  // NOTE: combinational next-state uses blocking assignments and assigns every
  // output on every path, so no latch can be inferred.
  always_comb begin
    sum_bit = a_q[0] ^ b_q[0] ^ carry_q;
    carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    res_d   = {sum_bit, res_q};
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values, and every register (there is no memory array) is
  // cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= sub ? ~B : B;
            carry_q <= sub ? 1'b1 : Cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_d[WIDTH-1:1];
          carry_q <= carry_d;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            // carry_q here is the carry into the MSB; carry_d is the carry out.
            s_q     <= res_d;
            cout_q  <= carry_d;
            v_q     <= carry_q ^ carry_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;
  assign V    = v_q;

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Self-checking bench for serial_add_sub_unit: directed vectors, handshake and
// reset corner cases, and random operations against an arithmetic model.
module tb_serial_add_sub_unit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         busy, done, Cout, V;
  logic [W-1:0] S;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] last_s = '0;

  serial_add_sub_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .S(S), .Cout(Cout), .V(V)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sb;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
    logic         v;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input logic sb, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic ci, output logic [W-1:0] s, output logic co,
                                output logic v);
    int ua, ub, sa, sbi, tot, st;
    ua  = int'(a);
    ub  = int'(b);
    sa  = (ua >= 2**(W-1)) ? ua - 2**W : ua;
    sbi = (ub >= 2**(W-1)) ? ub - 2**W : ub;
    if (sb) begin
      tot = ua + (2**W - 1 - ub) + 1;
      st  = sa - sbi;
    end else begin
      tot = ua + ub + int'(ci);
      st  = sa + sbi + int'(ci);
    end
    s  = W'(tot % (2**W));
    co = (tot >= 2**W);
    v  = (st > 2**(W-1) - 1) || (st < -(2**(W-1)));
  endfunction

  // Called at a negedge with the DUT idle. poke > 0 pulses start with other
  // operands during that RUN cycle; it must be ignored.
  task automatic run_op(input logic sb, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input int poke, output logic [W-1:0] s,
                        output logic co, output logic v);
    int lat;
    start = 1'b1; sub = sb; A = a; B = b; Cin = ci;
    @(posedge clk);
    #1;
    start = 1'b0; A = ~a; B = ~b; sub = ~sb; Cin = ~ci;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      start = (lat == poke);
      if (lat == poke) begin A = b; B = a; end
      if (!done) check("s_hold_during_run", S, last_s);
    end while (!done && lat < 4 * W);
    start = 1'b0;
    check("done_latency", lat, W);
    s = S; co = Cout; v = V;
    last_s = S;
    @(posedge clk);
    #1;
    check("done_width", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    vec_t vecs[$];
    logic [W-1:0] s_act, s_exp;
    logic co_act, v_act, co_exp, v_exp;

    // Directed vectors with hand-derived expectations.
    vecs.push_back('{1'b0, 4'd5,  4'd6, 1'b0, 4'hB, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'd9,  4'd3, 1'b0, 4'd6, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 4'd6,  4'd3, 1'b0, 4'd9, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'd3,  4'd5, 1'b1, 4'hE, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'd15, 4'd1, 1'b1, 4'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd7,  4'd8, 1'b0, 4'hF, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd0,  4'd0, 1'b0, 4'd0, 1'b1, 1'b0});

    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_s", S, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].sb, vecs[i].a, vecs[i].b, vecs[i].ci, 0, s_act, co_act, v_act);
      check($sformatf("vec%0d_s", i), s_act, vecs[i].s);
      check($sformatf("vec%0d_cout", i), co_act, vecs[i].co);
      check($sformatf("vec%0d_v", i), v_act, vecs[i].v);
    end

    // start pulsed mid-RUN with swapped operands: 5 + 6 must still result.
    run_op(1'b0, 4'd5, 4'd6, 1'b0, 2, s_act, co_act, v_act);
    check("ignore_start_s", s_act, 4'hB);
    check("ignore_start_v", v_act, 1'b1);

    // start held high: one result every W+2 cycles, S stable in between.
    begin
      int cyc, last_done, pulses;
      start = 1'b1; sub = 1'b0; A = 4'd2; B = 4'd3; Cin = 1'b1;
      cyc = 0; last_done = -1; pulses = 0;
      while (pulses < 3 && cyc < 40) begin
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
          if (last_done >= 0) check("hold_start_period", cyc - last_done, W + 2);
          check("hold_start_s", S, 4'd6);
          last_done = cyc;
          pulses++;
          last_s = S;
        end else begin
          check("hold_start_s_stable", S, last_s);
        end
      end
      check("hold_start_pulses", pulses, 3);
      start = 1'b0;
      repeat (W + 2) @(posedge clk);
      @(negedge clk);
    end

    // Asynchronous reset during the second RUN cycle.
    start = 1'b1; sub = 1'b0; A = 4'd9; B = 4'd9; Cin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_s", S, '0);
    check("midrst_cout", Cout, 1'b0);
    check("midrst_v", V, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    last_s = '0;
    repeat (W + 2) begin
      @(posedge clk);
      #1;
      check("midrst_no_done", done, 1'b0);
    end
    @(negedge clk);
    run_op(1'b1, 4'd7, 4'd8, 1'b0, 0, s_act, co_act, v_act);
    check("post_rst_s", s_act, 4'hF);
    check("post_rst_cout", co_act, 1'b0);
    check("post_rst_v", v_act, 1'b1);

    // Random operations against the arithmetic model.
    for (int k = 0; k < 40; k++) begin
      logic sb_r, ci_r;
      logic [W-1:0] a_r, b_r;
      sb_r = 1'($urandom);
      ci_r = 1'($urandom);
      a_r  = W'($urandom);
      b_r  = W'($urandom);
      model(sb_r, a_r, b_r, ci_r, s_exp, co_exp, v_exp);
      run_op(sb_r, a_r, b_r, ci_r, (k % 3 == 0) ? 1 : 0, s_act, co_act, v_act);
      check($sformatf("rand%0d_s", k), s_act, s_exp);
      check($sformatf("rand%0d_cout", k), co_act, co_exp);
      check($sformatf("rand%0d_v", k), v_act, v_exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
